vga_frame_driver: RTL and testbench
===================================

// Module: vga_frame_driver
// PURPOSE
//  Source end of the pixel interface. Generates the DrawX/DrawY raster sent to color_mapper.
//  Takes the returned 24-bit RGB, delay-matches it with HS/VS/blank, and drives the VGA DAC pins.
//  Also gives game logic one-cycle frame/line strobes for per-frame sprite and state updates.
// PARAMETERS
//  H_VISIBLE  640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_VISIBLE  480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BP       33   vertical back porch (lines)
//  PIPE_DELAY 2    pix_en ticks from DrawX/DrawY change to valid RGB at RGB_in (0..7)
// PORTS
//  Clk          in   1   system clock (50 MHz)
//  Reset_n      in   1   asynchronous reset, active-low
//  pix_en       in   1   pixel-clock enable (1-in-2 Clk for 25 MHz); all state advances only when high
//  RGB_in       in   24  {R,G,B} from color_mapper for the DrawX/DrawY of PIPE_DELAY ticks earlier
//  DrawX        out  10  current horizontal count, 0..H_TOTAL-1
//  DrawY        out  10  current vertical count, 0..V_TOTAL-1
//  VGA_HS       out  1   horizontal sync, active-low
//  VGA_VS       out  1   vertical sync, active-low
//  VGA_BLANK_N  out  1   1 = visible pixel on the DAC
//  VGA_SYNC_N   out  1   tied 0 (no sync-on-green)
//  VGA_R/G/B    out  8   DAC colour; forced 0 when blanked
//  frame_start  out  1   one-Clk pulse on the tick where DrawX/DrawY wrap to (0,0)
//  line_start   out  1   one-Clk pulse on every tick where DrawX wraps to 0
// BEHAVIOUR
//  - Totals: H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  - Counters (registers, update only on Clk edge with pix_en=1):
//      DrawX = H_TOTAL-1 -> 0, and DrawY increments.
//      DrawY = V_TOTAL-1 together with DrawX wrap -> DrawY 0.
//      pix_en=0: every register holds, including pipeline, outputs and strobes low.
//  - Raw per-count decode (combinational from counters):
//      vis = DrawX<H_VISIBLE && DrawY<V_VISIBLE
//      hs  = !(DrawX in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1])
//      vs  = !(DrawY in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1])
//  - Alignment: {vis,hs,vs} pass through a PIPE_DELAY-deep shift register clocked on pix_en.
//      On each pix_en, the output registers load:
//        VGA_HS/VS/BLANK_N <- delayed hs/vs/vis
//        VGA_R/G/B         <- delayed vis ? RGB_in : 0
//      Total latency from a counter value to its pins is PIPE_DELAY+1 ticks; all pins mutually aligned.
//      PIPE_DELAY=0: the delay line is bypassed and latency is 1.
//  - Strobes: registered; high for exactly the one Clk of the pix_en tick that loads the wrap value, else 0.
//      frame_start implies line_start in the same cycle.
//  - Reset (async assert, sync deassert via Reset_n edge sampling of flops):
//      DrawX=DrawY=0; pipeline cleared to vis=0/hs=1/vs=1.
//      VGA_HS=VGA_VS=1, VGA_BLANK_N=0, RGB=0, strobes=0.
//      No partial frame resumes: reset mid-line restarts at (0,0).
//      First frame_start is the first wrap after reset, not the reset itself.
//  - Counters are never written outside 0..TOTAL-1; no out-of-range states exist.
// TESTING
//  1 Reset: hold Reset_n=0 with pix_en toggling -> DrawX=DrawY=0, HS=VS=1, BLANK_N=0, RGB=0, strobes 0.
//  2 Line timing, PIPE_DELAY=2:
//      VGA_HS low for exactly 96 pix_en ticks.
//      Falling edge lands 3 ticks after DrawX=656; line period 800 ticks; line_start once per 800.
//  3 Frame timing: VGA_VS low for 2 lines (1600 ticks) starting 3 ticks after DrawY=490,DrawX=0.
//      frame_start every 420000 pix_en ticks.
//  4 Blank/colour alignment: RGB_in = {DrawX-delayed by 2 stub, 8'h00, 8'hFF}.
//      R pin equals DrawX-3 while visible; pins read 000000 for DrawX>=640 delayed and in rows >=480.
//  5 pix_en held 0 for 50 Clk mid-line -> all outputs and counters frozen; resume continues the count.
//  6 Reset_n pulsed low at DrawX=300,DrawY=200 -> outputs take reset values asynchronously.
//      Restart from (0,0); next frame_start 420000 ticks later.

Source files
------------

// File: rtl/vga_frame_driver.sv
// VGA raster source: DrawX/DrawY counters, sync/blank decode, a delay line matching the
// colour pipeline latency, registered DAC pins and one-cycle frame/line strobes.
module vga_frame_driver #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_en,
  input  logic [23:0] RGB_in,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        frame_start,
  output logic        line_start
);

  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } ctl_t;

  // Idle/blanked control word: not visible, both syncs inactive (high).
  localparam ctl_t CTL_IDLE = 3'b011;

  function automatic logic [23:0] gate_rgb(input logic vis, input logic [23:0] rgb);
    return vis ? rgb : 24'h000000;
  endfunction

  logic line_wrap;
  logic frame_wrap;
  ctl_t ctl_p0;
  ctl_t ctl_dly;

  assign line_wrap  = (DrawX == H_LAST);
  assign frame_wrap = line_wrap && (DrawY == V_LAST);
  assign VGA_SYNC_N = 1'b0;

  // Stage p0: raster counters and combinational decode of the current count
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DrawX <= '0;
      DrawY <= '0;
    end else if (pix_en) begin
      DrawX <= line_wrap ? '0 : DrawX + 10'd1;
      if (line_wrap)
        DrawY <= frame_wrap ? '0 : DrawY + 10'd1;
    end
  end

  // Strobes fire in the Clk that follows the wrapping pix_en edge, and only that one.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en && line_wrap;
      frame_start <= pix_en && frame_wrap;
    end
  end

  always_comb begin
    ctl_p0     = CTL_IDLE;
    ctl_p0.vis = (DrawX < H_VIS) && (DrawY < V_VIS);
    ctl_p0.hs  = !((DrawX >= HS_BEG) && (DrawX <= HS_END));
    ctl_p0.vs  = !((DrawY >= VS_BEG) && (DrawY <= VS_END));
  end

  // Stage p1: delay line matching the colour_mapper latency
  if (PIPE_DELAY == 0) begin : g_bypass
    assign ctl_dly = ctl_p0;
  end else begin : g_delay
    ctl_t sr_p1 [PIPE_DELAY];

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        for (int i = 0; i < PIPE_DELAY; i++)
          sr_p1[i] <= CTL_IDLE;
      end else if (pix_en) begin
        sr_p1[0] <= ctl_p0;
        for (int i = 1; i < PIPE_DELAY; i++)
          sr_p1[i] <= sr_p1[i-1];
      end
    end

    assign ctl_dly = sr_p1[PIPE_DELAY-1];
  end

  // Stage p2: registered DAC pins, colour gated by the aligned visible flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_HS                <= 1'b1;
      VGA_VS                <= 1'b1;
      VGA_BLANK_N           <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= 24'h000000;
    end else if (pix_en) begin
      VGA_HS                <= ctl_dly.hs;
      VGA_VS                <= ctl_dly.vs;
      VGA_BLANK_N           <= ctl_dly.vis;
      {VGA_R, VGA_G, VGA_B} <= gate_rgb(ctl_dly.vis, RGB_in);
    end
  end

endmodule

// File: tb/tb_vga_frame_driver.sv
// Bench for vga_frame_driver on a reduced raster: scoreboard of per-tick pin values,
// timing measurements, freeze and mid-line reset sequences, and a table of decode points.
module tb_vga_frame_driver;

  localparam int HV = 16, HFP = 2, HSW = 4, HBP = 3;
  localparam int VV = 6,  VFP = 1, VSW = 2, VBP = 2;
  localparam int PD = 2;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VT = VV + VFP + VSW + VBP;
  localparam int LAT = PD + 1;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [23:0] RGB_in = 24'h0;
  logic [9:0]  DrawX, DrawY;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        frame_start, line_start;

  vga_frame_driver #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIPE_DELAY(PD)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .RGB_in(RGB_in),
    .DrawX(DrawX), .DrawY(DrawY),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          x;
    int          y;
    logic        hs;
    logic        vs;
    logic        bn;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    int         x;
    int         y;
    logic       hs;
    logic       vs;
    logic       bn;
    logic [7:0] r;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  vec_t tbl [14];
  logic [10:0] seen [VT][HT];
  bit          seen_ok [VT][HT];

  int n_pass = 0, n_total = 0;
  int mx, my, hx1, hx2, ticks;
  bit hv1, hv2;
  int t_xref, t_hfall, t_yref, t_vfall, t_line, t_frame;
  logic hs_prev, vs_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (tick %0d)", name, act, exp, ticks);
  endtask

  task automatic model_reset();
    exp_t r;
    mx = 0; my = 0; hv1 = 0; hv2 = 0; hx1 = 0; hx2 = 0; ticks = 0;
    t_xref = -1; t_hfall = -1; t_yref = -1; t_vfall = -1; t_line = 0; t_frame = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
    sb.delete();
    r.x = -1; r.y = -1; r.hs = 1'b1; r.vs = 1'b1; r.bn = 1'b0; r.rgb = 24'h0;
    for (int i = 0; i < PD; i++) sb.push_back(r);
    last_exp = r;
  endtask

  // One pix_en tick (pix_en high for one Clk, low for the next); starts and ends at a negedge.
  task automatic tick();
    exp_t e, got;
    bit el, ef;
    e.x = mx; e.y = my;
    e.bn  = (mx < HV) && (my < VV);
    e.hs  = !((mx >= HV + HFP) && (mx < HV + HFP + HSW));
    e.vs  = !((my >= VV + VFP) && (my < VV + VFP + VSW));
    e.rgb = e.bn ? {8'(mx), 8'h00, 8'hFF} : 24'h0;
    sb.push_back(e);
    RGB_in = hv2 ? {8'(hx2), 8'h00, 8'hFF} : 24'h0;
    pix_en = 1'b1;
    @(posedge Clk);
    el = (mx == HT - 1);
    ef = el && (my == VT - 1);
    hx2 = hx1; hv2 = hv1; hx1 = mx; hv1 = 1'b1;
    if (el) begin
      mx = 0;
      my = ef ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    @(negedge Clk);
    pix_en = 1'b0;
    ticks++;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      last_exp = got;
      check("pins", {5'b0, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B},
                    {5'b0, got.hs, got.vs, got.bn, got.rgb});
      if (got.x >= 0) begin
        seen[got.y][got.x]    = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R};
        seen_ok[got.y][got.x] = 1'b1;
      end
    end
    check("draw_xy", {12'b0, DrawY, DrawX}, {12'b0, 10'(my), 10'(mx)});
    check("strobes", {30'b0, frame_start, line_start}, {30'b0, ef, el});
    if (DrawX == 10'(HV + HFP)) t_xref = ticks;
    if (hs_prev && !VGA_HS) begin
      if (t_xref >= 0) check("hs_fall_lag", ticks - t_xref, LAT);
      t_hfall = ticks;
    end
    if (!hs_prev && VGA_HS && t_hfall >= 0) check("hs_width", ticks - t_hfall, HSW);
    hs_prev = VGA_HS;
    if (DrawY == 10'(VV + VFP) && DrawX == 10'd0) t_yref = ticks;
    if (vs_prev && !VGA_VS) begin
      if (t_yref >= 0) check("vs_fall_lag", ticks - t_yref, LAT);
      t_vfall = ticks;
    end
    if (!vs_prev && VGA_VS && t_vfall >= 0) check("vs_width", ticks - t_vfall, VSW * HT);
    vs_prev = VGA_VS;
    if (line_start) begin
      check("line_period", ticks - t_line, HT);
      t_line = ticks;
    end
    if (frame_start) begin
      check("frame_period", ticks - t_frame, HT * VT);
      check("frame_has_line", {31'b0, line_start}, 32'd1);
      t_frame = ticks;
    end
    @(posedge Clk);
    @(negedge Clk);
    check("idle_strobes", {30'b0, frame_start, line_start}, 32'd0);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_xy"}, {12'b0, DrawY, DrawX}, 32'd0);
    check({tag, "_sync"}, {29'b0, VGA_HS, VGA_VS, VGA_BLANK_N}, 32'b110);
    check({tag, "_rgb"}, {8'b0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check({tag, "_strobes"}, {30'b0, frame_start, line_start}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{0,  0,  1'b1, 1'b1, 1'b1, 8'd0};
    tbl[1]  = '{15, 0,  1'b1, 1'b1, 1'b1, 8'd15};
    tbl[2]  = '{16, 0,  1'b1, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{17, 2,  1'b1, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{18, 2,  1'b0, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{21, 2,  1'b0, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{22, 2,  1'b1, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{24, 5,  1'b1, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{7,  5,  1'b1, 1'b1, 1'b1, 8'd7};
    tbl[9]  = '{3,  6,  1'b1, 1'b1, 1'b0, 8'd0};
    tbl[10] = '{0,  7,  1'b1, 1'b0, 1'b0, 8'd0};
    tbl[11] = '{19, 8,  1'b0, 1'b0, 1'b0, 8'd0};
    tbl[12] = '{0,  9,  1'b1, 1'b1, 1'b0, 8'd0};
    tbl[13] = '{24, 10, 1'b1, 1'b1, 1'b0, 8'd0};
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) seen_ok[y][x] = 1'b0;
    ticks = 0;

    // Reset held with pix_en toggling and live colour input
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      pix_en = ~pix_en;
      RGB_in = 24'hABCDEF;
      @(negedge Clk);
    end
    check_reset_pins("reset");
    check("sync_n", {31'b0, VGA_SYNC_N}, 32'd0);
    pix_en = 1'b0;
    RGB_in = 24'h0;
    Reset_n = 1'b1;
    model_reset();

    // Two full frames plus a few lines
    for (int i = 0; i < 2 * HT * VT + 10; i++) tick();

    // Freeze mid-line with pix_en low for 50 Clk
    for (int g = 0; g < 2 * HT * VT && !(mx == 5 && my == 2); g++) tick();
    for (int i = 0; i < 50; i++) begin
      RGB_in = 24'($urandom);
      @(negedge Clk);
      if (frame_start || line_start) check("freeze_strobe", {30'b0, frame_start, line_start}, 32'd0);
    end
    check("freeze_xy", {12'b0, DrawY, DrawX}, {12'b0, 10'd2, 10'd5});
    check("freeze_pins", {5'b0, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B},
                         {5'b0, last_exp.hs, last_exp.vs, last_exp.bn, last_exp.rgb});
    for (int i = 0; i < 40; i++) tick();

    // Asynchronous reset pulse mid-line, then a full frame from (0,0)
    for (int g = 0; g < 2 * HT * VT && !(mx == 10 && my == 3); g++) tick();
    check("pre_reset_xy", {12'b0, DrawY, DrawX}, {12'b0, 10'd3, 10'd10});
    #2 Reset_n = 1'b0;
    #1 check_reset_pins("async_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < HT * VT + 5; i++) tick();
    check("restart_frame_tick", t_frame, HT * VT);

    // Decode/alignment table against pins recorded during the frames above
    for (int i = 0; i < 14; i++) begin
      if (!seen_ok[tbl[i].y][tbl[i].x])
        check("tbl_seen", 32'd0, 32'd1);
      else
        check($sformatf("tbl_%0d_%0d", tbl[i].x, tbl[i].y),
              {21'b0, seen[tbl[i].y][tbl[i].x]},
              {21'b0, tbl[i].hs, tbl[i].vs, tbl[i].bn, tbl[i].r});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
